sig_ctrl: RTL and testbench

- Front-panel control stage that sits directly upstream of the waveform generator. It drives that generator's cnt_sig, cnt_amp, cnt_fre, cnt_phase and confirm inputs.
- It takes three raw active-low push-buttons and synchronises and debounces them. It turns each press into a one-cycle event.
- A small edit/run state machine uses those events to select and step the four 2-bit settings. It also gates output enable (confirm).

---
 rtl/sig_ctrl.sv | 154 +++++++++++++++
 tb/tb_sig_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sig_ctrl.sv
// Front-panel control: debounced active-low keys drive an edit/run FSM that steps four 2-bit generator settings.
// Key-to-output latency is DEB_CYCLES+4 cycles; all outputs registered, no backpressure (events are single-cycle pulses).

module sig_ctrl_key #(
    parameter logic [19:0] DEB_CYCLES    = 20'd500000,
    parameter logic [23:0] REPEAT_CYCLES = 24'd0
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic evt
);
    logic        sync_1;
    logic        sync_2;
    logic        level;
    logic        level_q;
    logic [19:0] deb_cnt;
    logic [23:0] rep_cnt;
    logic        held;
    logic        rep_hit;

    // held only once the registered level is also low, so repeats are spaced from the initial press pulse
    assign held    = ~level & ~level_q;
    assign rep_hit = (REPEAT_CYCLES != 24'd0) && held && (rep_cnt == REPEAT_CYCLES - 24'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            level   <= 1'b1;
            level_q <= 1'b1;
            deb_cnt <= '0;
            rep_cnt <= '0;
            evt     <= 1'b0;
        end else begin
            sync_1  <= key;
            sync_2  <= sync_1;
            level_q <= level;
            evt     <= (level_q & ~level) | rep_hit;

            if (sync_2 == level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_CYCLES - 20'd1) begin
                level   <= sync_2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 20'd1;
            end

            if ((REPEAT_CYCLES == 24'd0) || !held || rep_hit)
                rep_cnt <= '0;
            else
                rep_cnt <= rep_cnt + 24'd1;
        end
    end
endmodule

module sig_ctrl #(
    parameter logic [19:0] DEB_CYCLES    = 20'd500000,
    parameter logic [23:0] REPEAT_CYCLES = 24'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_ok,
    output logic [1:0] cnt_sig,
    output logic [1:0] cnt_amp,
    output logic [1:0] cnt_fre,
    output logic [1:0] cnt_phase,
    output logic       confirm,
    output logic [1:0] sel_field
);
    typedef enum logic {EDIT = 1'b0, RUN = 1'b1} state_t;

    logic   ok_raw, mode_raw, up_raw;
    logic   evt_ok, evt_mode, evt_up;
    state_t state_q, state_d;
    logic [1:0] sel_d, sig_d, amp_d, fre_d, phase_d;
    logic       confirm_d;

    sig_ctrl_key #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(24'd0)) u_key_ok (
        .clk(clk), .rst(rst), .key(key_ok), .evt(ok_raw)
    );
    sig_ctrl_key #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(24'd0)) u_key_mode (
        .clk(clk), .rst(rst), .key(key_mode), .evt(mode_raw)
    );
    sig_ctrl_key #(.DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_key_up (
        .clk(clk), .rst(rst), .key(key_up), .evt(up_raw)
    );

    // Registered priority resolution: ok > mode > up, losers are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_ok   <= 1'b0;
            evt_mode <= 1'b0;
            evt_up   <= 1'b0;
        end else begin
            evt_ok   <= ok_raw;
            evt_mode <= mode_raw & ~ok_raw;
            evt_up   <= up_raw & ~ok_raw & ~mode_raw;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_field;
        sig_d   = cnt_sig;
        amp_d   = cnt_amp;
        fre_d   = cnt_fre;
        phase_d = cnt_phase;
        case (state_q)
            EDIT: begin
                if (evt_ok) begin
                    state_d = RUN;
                end else if (evt_mode) begin
                    sel_d = sel_field + 2'd1;
                end else if (evt_up) begin
                    case (sel_field)
                        2'd0:    sig_d   = cnt_sig + 2'd1;
                        2'd1:    amp_d   = cnt_amp + 2'd1;
                        2'd2:    fre_d   = cnt_fre + 2'd1;
                        default: phase_d = cnt_phase + 2'd1;
                    endcase
                end
            end
            default: begin
                if (evt_ok)
                    state_d = EDIT;
            end
        endcase
        confirm_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EDIT;
            sel_field <= '0;
            cnt_sig   <= '0;
            cnt_amp   <= '0;
            cnt_fre   <= '0;
            cnt_phase <= '0;
            confirm   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_field <= sel_d;
            cnt_sig   <= sig_d;
            cnt_amp   <= amp_d;
            cnt_fre   <= fre_d;
            cnt_phase <= phase_d;
            confirm   <= confirm_d;
        end
    end
endmodule

// File: tb/tb_sig_ctrl.sv
// Directed bench for sig_ctrl with DEB_CYCLES=4: one instance without auto-repeat, one with REPEAT_CYCLES=10.
module tb_sig_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_mode = 1'b1, key_up = 1'b1, key_ok = 1'b1;
    logic r_key_up = 1'b1;
    logic [1:0] cnt_sig, cnt_amp, cnt_fre, cnt_phase, sel_field;
    logic       confirm;
    logic [1:0] r_sig, r_amp, r_fre, r_phase, r_sel;
    logic       r_confirm;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sig_ctrl #(.DEB_CYCLES(20'd4), .REPEAT_CYCLES(24'd0)) u_dut (
        .clk(clk), .rst(rst), .key_mode(key_mode), .key_up(key_up), .key_ok(key_ok),
        .cnt_sig(cnt_sig), .cnt_amp(cnt_amp), .cnt_fre(cnt_fre), .cnt_phase(cnt_phase),
        .confirm(confirm), .sel_field(sel_field)
    );

    sig_ctrl #(.DEB_CYCLES(20'd4), .REPEAT_CYCLES(24'd10)) u_rep (
        .clk(clk), .rst(rst), .key_mode(1'b1), .key_up(r_key_up), .key_ok(1'b1),
        .cnt_sig(r_sig), .cnt_amp(r_amp), .cnt_fre(r_fre), .cnt_phase(r_phase),
        .confirm(r_confirm), .sel_field(r_sel)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Waits n rising edges, then settles 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int sig, input int amp, input int fre,
                             input int phase, input int sel, input int conf);
        check({tag, ".sig"},   int'(cnt_sig),   sig);
        check({tag, ".amp"},   int'(cnt_amp),   amp);
        check({tag, ".fre"},   int'(cnt_fre),   fre);
        check({tag, ".phase"}, int'(cnt_phase), phase);
        check({tag, ".sel"},   int'(sel_field), sel);
        check({tag, ".conf"},  int'(confirm),   conf);
    endtask

    // 0: mode, 1: up, 2: ok; held 8 cycles then released for 12
    task automatic press(input int which);
        case (which)
            0: key_mode = 1'b0;
            1: key_up   = 1'b0;
            default: key_ok = 1'b0;
        endcase
        step(8);
        key_mode = 1'b1;
        key_up   = 1'b1;
        key_ok   = 1'b1;
        step(12);
    endtask

    initial begin
        #1;
        check_all("rst", 0, 0, 0, 0, 0, 0);
        step(3);
        rst = 1'b0;
        step(100);
        check_all("idle", 0, 0, 0, 0, 0, 0);
        check("rep_idle.sig", int'(r_sig), 0);

        // Exact latency: press sampled on the next edge, output updates 8 edges later
        key_up = 1'b0;
        step(8);
        check("lat.before", int'(cnt_sig), 0);
        step(1);
        check("lat.edge8", int'(cnt_sig), 1);
        step(11);
        check("lat.held", int'(cnt_sig), 1);
        key_up = 1'b1;
        step(20);
        check("lat.release", int'(cnt_sig), 1);

        // Bounce shorter than the debounce window
        key_up = 1'b0; step(3);
        key_up = 1'b1; step(2);
        key_up = 1'b0; step(3);
        key_up = 1'b1; step(20);
        check("bounce", int'(cnt_sig), 1);
        press(1);
        check("bounce.clean", int'(cnt_sig), 2);

        press(0);
        press(1);
        press(1);
        check_all("edit_amp", 2, 2, 0, 0, 1, 0);
        press(1);
        press(1);
        check("amp_wrap", int'(cnt_amp), 0);

        press(2);
        check("run.conf", int'(confirm), 1);
        press(1);
        press(0);
        check_all("run.ignore", 2, 0, 0, 0, 1, 1);
        press(2);
        check_all("back_edit", 2, 0, 0, 0, 1, 0);

        // ok and up fall together: ok wins, up is discarded
        key_ok = 1'b0;
        key_up = 1'b0;
        step(8);
        key_ok = 1'b1;
        key_up = 1'b1;
        step(12);
        check_all("simul", 2, 0, 0, 0, 1, 1);

        // Auto-repeat instance: first event on edge 9, then one every 10 edges
        r_key_up = 1'b0;
        step(9);
        check("rep.first", int'(r_sig), 1);
        step(10);
        check("rep.r1", int'(r_sig), 2);
        step(10);
        check("rep.r2", int'(r_sig), 3);
        step(10);
        check("rep.r3", int'(r_sig), 0);
        step(10);
        check("rep.r4", int'(r_sig), 1);
        r_key_up = 1'b1;
        step(30);
        check("rep.release", int'(r_sig), 1);
        check("rep.sel", int'(r_sel), 0);

        // Async reset while in RUN: no clock edge between assert and check
        check("pre_rst.conf", int'(confirm), 1);
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0);
        check("async_rst.rep", int'(r_sig), 0);

        // Key held through reset release needs a full debounce and gives one event
        key_up = 1'b0;
        step(2);
        rst = 1'b0;
        step(8);
        check("held_rst.before", int'(cnt_sig), 0);
        step(1);
        check("held_rst.event", int'(cnt_sig), 1);
        step(20);
        key_up = 1'b1;
        step(20);
        check("held_rst.single", int'(cnt_sig), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
